// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared definitions for the execution unit: function-select
//               opcodes, PSR bit positions, memory-write / writeback-select
//               encodings and the sequential multiplier state type.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    // Function-select opcodes
    localparam logic [4:0] FS_PASS_A = 5'b00000;
    localparam logic [4:0] FS_INC_A  = 5'b00001;
    localparam logic [4:0] FS_ADD    = 5'b00010;
    localparam logic [4:0] FS_SUB    = 5'b00101;
    localparam logic [4:0] FS_DEC_A  = 5'b00110;
    localparam logic [4:0] FS_AND    = 5'b01000;
    localparam logic [4:0] FS_OR     = 5'b01010;
    localparam logic [4:0] FS_XOR    = 5'b01100;
    localparam logic [4:0] FS_NOT_A  = 5'b01110;
    localparam logic [4:0] FS_PASS_B = 5'b10000;
    localparam logic [4:0] FS_LSL    = 5'b10100;
    localparam logic [4:0] FS_LSR    = 5'b11000;
    localparam logic [4:0] FS_ASR    = 5'b10101;
    localparam logic [4:0] FS_ROR    = 5'b11001;
    localparam logic [4:0] FS_MUL    = 5'b11100;

    // PSR layout is {V,C,N,Z}
    localparam int PSR_Z = 0;
    localparam int PSR_N = 1;
    localparam int PSR_C = 2;
    localparam int PSR_V = 3;

    // Memory-write select
    typedef enum logic {
        MW_ALU = 1'b0,
        MW_MEM = 1'b1
    } mw_sel_t;

    // Writeback-source select, carried through to MD_1 for the next stage
    typedef enum logic [1:0] {
        MD_FUNC = 2'b00,
        MD_DATA = 2'b01,
        MD_PC   = 2'b10,
        MD_RSVD = 2'b11
    } md_sel_t;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/exec_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : exec_mul_seq
// Description : Unsigned shift-add multiplier, one partial product per cycle.
//               i_start loads the operands; WIDTH iterations follow with
//               o_busy high. o_done is high during the final iteration cycle
//               and o_product then carries the completed 2*WIDTH-bit product
//               so the caller can capture it on that same edge.
// Ports       : CLK, reset (async active-low)
//               i_start, i_a, i_b          - launch a multiply
//               o_busy, o_done, o_product  - status and result
// Revision    : 1.0 - initial release
// ============================================================================
module exec_mul_seq
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_t             r_state;
    logic [WIDTH-1:0]       r_mcand;
    // Upper half accumulates partial sums, lower half holds the unconsumed
    // multiplier bits; both shift right one place per iteration.
    logic [2*WIDTH-1:0]     r_prod;
    logic [CNT_W-1:0]       r_cnt;

    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_next;
    logic                   w_last;

    assign w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                  + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_next = {w_sum, r_prod[WIDTH-1:1]};
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    assign o_busy    = (r_state == MUL_RUN);
    assign o_done    = (r_state == MUL_RUN) && w_last;
    assign o_product = w_next;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= MUL_IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_prod  <= {{WIDTH{1'b0}}, i_b};
                        r_cnt   <= '0;
                        r_state <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    r_prod <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= MUL_IDLE;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_unit_param.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit_param
// Description : Parameterised execution unit. Single-cycle ALU/shifter,
//               sequential multiplier, memory-op address/data formation and
//               a {V,C,N,Z} status register, behind valid/ready handshakes.
// Ports       : CLK, reset (async active-low, released to CLK)
//               in_valid/in_ready, PC_2, A, B, FS, SH, MW, PS, RW, DA, MD
//               out_valid/out_ready, FUNC_OUT, DATA_OUT, ADDR_OUT, PC_OUT,
//               RW_1, DA_1, MD_1, PSR, NxorV, busy
// Revision    : 1.0 - initial release
// ============================================================================
module exec_unit_param
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PC_W  = 16,
    parameter int DA_W  = 5
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            PC_2,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic [4:0]                 FS,
    input  logic [$clog2(WIDTH)-1:0]   SH,
    input  logic                       MW,
    input  logic                       PS,
    input  logic                       RW,
    input  logic [DA_W-1:0]            DA,
    input  logic [1:0]                 MD,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           FUNC_OUT,
    output logic [WIDTH-1:0]           DATA_OUT,
    output logic [PC_W-1:0]            ADDR_OUT,
    output logic [PC_W-1:0]            PC_OUT,
    output logic                       RW_1,
    output logic [DA_W-1:0]            DA_1,
    output logic [1:0]                 MD_1,
    output logic [3:0]                 PSR,
    output logic                       NxorV,
    output logic                       busy
);

    localparam int SH_W = $clog2(WIDTH);

    // Output and status registers
    logic                r_run;        // goes high on the first edge after reset release
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_func;
    logic [WIDTH-1:0]    r_data;
    logic [PC_W-1:0]     r_addr;
    logic [PC_W-1:0]     r_pc;
    logic                r_rw;
    logic [DA_W-1:0]     r_da;
    logic [1:0]          r_md;
    logic [3:0]          r_psr;
    // Side-band of the multiply in flight
    logic [PC_W-1:0]     r_p_pc;
    logic [WIDTH-1:0]    r_p_b;
    logic                r_p_rw;
    logic [DA_W-1:0]     r_p_da;
    logic [1:0]          r_p_md;
    logic                r_p_ps;

    logic                w_accept, w_is_mul, w_mul_busy, w_mul_done;
    logic [2*WIDTH-1:0]  w_product;
    logic [WIDTH-1:0]    w_add_y, w_res, w_ror;
    logic                w_add_cin, w_add_v, w_c, w_v, w_op_ok;
    logic [WIDTH:0]      w_sum, w_lsl, w_lsr, w_asr;
    logic [SH_W:0]       w_ror_amt;
    logic [PC_W-1:0]     w_addr_a;
    logic [3:0]          w_flags, w_mul_flags;

    assign w_is_mul = (FS == FS_MUL) && (MW == MW_ALU);
    assign in_ready = r_run && !w_mul_busy && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    exec_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .CLK       (CLK),
        .reset     (reset),
        .i_start   (w_accept && w_is_mul),
        .i_a       (A),
        .i_b       (B),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // All add/subtract forms share one adder: A + y + cin.
    always_comb begin
        w_add_y   = '0;
        w_add_cin = 1'b0;
        case (FS)
            FS_INC_A: w_add_cin = 1'b1;
            FS_ADD:   w_add_y   = B;
            FS_SUB:   begin w_add_y = ~B; w_add_cin = 1'b1; end
            FS_DEC_A: w_add_y   = '1;
            default:  w_add_y   = '0;
        endcase
    end

    assign w_sum   = {1'b0, A} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_v = (A[WIDTH-1] == w_add_y[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    // One guard bit on each shifter catches the last bit shifted out;
    // it stays 0 when SH=0.
    assign w_lsl     = {1'b0, B} << SH;
    assign w_lsr     = {B, 1'b0} >> SH;
    assign w_asr     = $signed({B, 1'b0}) >>> SH;
    assign w_ror_amt = (SH_W+1)'(WIDTH) - {1'b0, SH};
    assign w_ror     = (B >> SH) | (B << w_ror_amt);

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_op_ok = 1'b1;
        case (FS)
            FS_PASS_A: w_res = A;
            FS_INC_A, FS_ADD, FS_SUB, FS_DEC_A: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_add_v;
            end
            FS_AND:    w_res = A & B;
            FS_OR:     w_res = A | B;
            FS_XOR:    w_res = A ^ B;
            FS_NOT_A:  w_res = ~A;
            FS_PASS_B: w_res = B;
            FS_LSL:    begin w_res = w_lsl[WIDTH-1:0]; w_c = w_lsl[WIDTH]; end
            FS_LSR:    begin w_res = w_lsr[WIDTH:1];   w_c = w_lsr[0];     end
            FS_ASR:    begin w_res = w_asr[WIDTH:1];   w_c = w_asr[0];     end
            FS_ROR:    begin w_res = w_ror;            w_c = w_lsr[0];     end
            FS_MUL:    w_res = '0;   // result comes from the multiplier
            default:   w_op_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_flags        = '0;
        w_flags[PSR_V] = w_v;
        w_flags[PSR_C] = w_c;
        w_flags[PSR_N] = w_res[WIDTH-1];
        w_flags[PSR_Z] = (w_res == '0);

        w_mul_flags        = '0;
        w_mul_flags[PSR_V] = |w_product[2*WIDTH-1:WIDTH];
        w_mul_flags[PSR_N] = w_product[WIDTH-1];
        w_mul_flags[PSR_Z] = (w_product[WIDTH-1:0] == '0);
    end

    generate
        if (PC_W <= WIDTH) begin : g_addr_trunc
            assign w_addr_a = A[PC_W-1:0];
        end else begin : g_addr_ext
            assign w_addr_a = {{(PC_W-WIDTH){1'b0}}, A};
        end
    endgenerate

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_run       <= 1'b0;
            r_out_valid <= 1'b0;
            r_func      <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_pc        <= '0;
            r_rw        <= 1'b0;
            r_da        <= '0;
            r_md        <= '0;
            r_psr       <= '0;
            r_p_pc      <= '0;
            r_p_b       <= '0;
            r_p_rw      <= 1'b0;
            r_p_da      <= '0;
            r_p_md      <= '0;
            r_p_ps      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_func      <= (MW == MW_MEM) ? A : w_res;
                r_data      <= B;
                r_addr      <= (MW == MW_MEM) ? w_addr_a : '0;
                r_pc        <= PC_2;
                r_rw        <= RW;
                r_da        <= DA;
                r_md        <= MD;
                if (PS && (MW == MW_ALU) && w_op_ok) begin
                    r_psr <= w_flags;
                end
            end else if (w_accept) begin
                // Any previous result left on this edge (in_ready implies it)
                r_out_valid <= 1'b0;
                r_p_pc      <= PC_2;
                r_p_b       <= B;
                r_p_rw      <= RW;
                r_p_da      <= DA;
                r_p_md      <= MD;
                r_p_ps      <= PS;
            end else if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_func      <= w_product[WIDTH-1:0];
                r_data      <= r_p_b;
                r_addr      <= '0;
                r_pc        <= r_p_pc;
                r_rw        <= r_p_rw;
                r_da        <= r_p_da;
                r_md        <= r_p_md;
                if (r_p_ps) begin
                    r_psr <= w_mul_flags;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign FUNC_OUT  = r_func;
    assign DATA_OUT  = r_data;
    assign ADDR_OUT  = r_addr;
    assign PC_OUT    = r_pc;
    assign RW_1      = r_rw;
    assign DA_1      = r_da;
    assign MD_1      = r_md;
    assign PSR       = r_psr;
    assign NxorV     = r_psr[PSR_N] ^ r_psr[PSR_V];
    assign busy      = w_mul_busy;

endmodule
`default_nettype wire
